sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, pointer width in bits; minimum 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default (1 << ADDRESS_WIDTH), storage words; no other value is legal.
REQ-004 SHALL have parameter ALMOST_FULL_LEVEL, default FIFO_DEPTH-2, almost-full threshold in words.
REQ-005 SHALL have parameter ALMOST_EMPTY_LEVEL, default 2, almost-empty threshold in words.
REQ-006 SHALL have ports:
- Clk  input  1  single clock, all logic on posedge.
- Clear_in  input  1  reset, synchronous, active-high.
- Data_in  input  DATA_WIDTH  write data.
- WriteEn_in  input  1  write request.
- Full_out  output  1  no free word.
- Data_out  output  DATA_WIDTH  read data.
- ReadEn_in  input  1  read request.
- Empty_out  output  1  no stored word.
- AlmostFull_out  output  1  count >= ALMOST_FULL_LEVEL.
- AlmostEmpty_out  output  1  count <= ALMOST_EMPTY_LEVEL.
- Count_out  output  ADDRESS_WIDTH+1  stored words, 0..FIFO_DEPTH.
- Overflow_out  output  1  sticky: write attempted while full.
- Underflow_out  output  1  sticky: read attempted while empty.

Function
REQ-007 Write accepted at a Clk edge iff WriteEn_in & ~Full_out; Data_in stored at write pointer, write pointer +1.
REQ-008 Read accepted at a Clk edge iff ReadEn_in & ~Empty_out; read pointer +1.
REQ-009 Pointers SHALL be binary, ADDRESS_WIDTH bits, wrapping FIFO_DEPTH-1 -> 0 with no gap or stall.
REQ-010 Count_out: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-011 Full_out = (Count_out == FIFO_DEPTH); Empty_out = (Count_out == 0); both decoded from registered state only, no combinational path from any input.
REQ-012 AlmostFull_out and AlmostEmpty_out SHALL be decoded from registered count per REQ-006 and follow Count_out in the same cycle.
REQ-013 Simultaneous read+write when full: read accepted, write rejected (Full_out gates), count -> FIFO_DEPTH-1.
REQ-014 Simultaneous read+write when empty: write accepted, read rejected, count -> 1.
REQ-015 Simultaneous read+write otherwise: both accepted, count unchanged, data order preserved.
REQ-016 Overflow_out set at edge where WriteEn_in & Full_out; Underflow_out set at edge where ReadEn_in & Empty_out; both cleared only by Clear_in.
REQ-017 Rejected operations SHALL NOT alter memory, pointers, count or Data_out.
REQ-018 Standard mode: Data_out loads the head word at the edge of an accepted read (latency 1) and holds otherwise.
REQ-019 Word written at edge N SHALL make Empty_out low after edge N.

Reset
REQ-020 Clear_in high at an edge SHALL set pointers 0, Count_out 0, Empty_out 1, Full_out 0, AlmostEmpty_out 1, AlmostFull_out 0, Overflow_out 0, Underflow_out 0, Data_out 0 (standard mode).
REQ-021 Clear_in SHALL override any concurrent read or write; memory contents need not be cleared.
REQ-022 Clear_in asserted mid-operation discards all stored words; the FIFO is usable the first edge after Clear_in falls.

Configuration
REQ-023 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; Data_out = memory at read pointer continuously, valid whenever Empty_out low; accepted read advances to the next word; Data_out undefined while Empty_out high.
REQ-024 SYNC_FIFO_FWFT_EN undefined: standard registered-read behaviour per REQ-018; all other requirements identical in both modes.

Verification (DATA_WIDTH 8, ADDRESS_WIDTH 4, default levels)
REQ-025 Clear, write 0x01..0x10 -> Full_out 1 after 16th write, Count_out 16, AlmostFull_out 1 from count 14; 17th write (0xAA) -> Overflow_out 1, contents unchanged.
REQ-026 Read 16 words from full -> Data_out 0x01..0x10 in order, Empty_out 1 after 16th, 17th read -> Underflow_out 1, Data_out holds 0x10.
REQ-027 Continuous read+write with count 5 for 40 cycles (pointers wrap twice) -> Count_out stays 5, output sequence matches input, no flag change.
REQ-028 Full plus read+write same edge -> Count_out 15, Full_out 0, written word dropped; empty plus read+write -> Count_out 1, Empty_out 0.
REQ-029 Clear_in pulsed with count 9 and WriteEn_in high -> next cycle Count_out 0, Empty_out 1, both sticky flags 0.
REQ-030 SYNC_FIFO_FWFT_EN build: write 0x5A into empty -> Data_out 0x5A and Empty_out 0 after that edge, before any ReadEn_in.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through output
// (Data_out shows the head word continuously). Without it, Data_out is a
// register that loads the head word on each accepted read and holds otherwise.
//
// FIFO_DEPTH must equal (1 << ADDRESS_WIDTH). The binary pointers rely on
// their natural wrap from FIFO_DEPTH-1 to 0.

module sync_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int FIFO_DEPTH         = (1 << ADDRESS_WIDTH),
  parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                     Clk,
  input  logic                     Clear_in,
  input  logic [DATA_WIDTH-1:0]    Data_in,
  input  logic                     WriteEn_in,
  output logic                     Full_out,
  output logic [DATA_WIDTH-1:0]    Data_out,
  input  logic                     ReadEn_in,
  output logic                     Empty_out,
  output logic                     AlmostFull_out,
  output logic                     AlmostEmpty_out,
  output logic [ADDRESS_WIDTH:0]   Count_out,
  output logic                     Overflow_out,
  output logic                     Underflow_out
);

  localparam int CW = ADDRESS_WIDTH + 1;

  localparam logic [CW-1:0]            DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]            AF_LEVEL_C = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0]            AE_LEVEL_C = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [CW-1:0]            CNT_ONE_C  = CW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE_C  = ADDRESS_WIDTH'(1);

  // Storage (not reset; Clear_in only discards the words logically).
  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;

  logic full;
  logic empty;
  logic wr_accept;
  logic rd_accept;

  // Request/accept rule: a request is a level sampled at the Clk edge.
  // WriteEn_in is accepted when the FIFO is not full and ReadEn_in when it is
  // not empty, both judged on the registered count before the edge. A
  // rejected request changes nothing except setting the matching sticky
  // error flag. Clear_in overrides both requests.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign wr_accept = WriteEn_in & ~full  & ~Clear_in;
  assign rd_accept = ReadEn_in  & ~empty & ~Clear_in;

  // Next-state for pointers, count and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (Clear_in) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
      if (WriteEn_in & full)  overflow_d  = 1'b1;
      if (ReadEn_in  & empty) underflow_d = 1'b1;
    end
  end

  // Control state registers with synchronous clear.
  always_ff @(posedge Clk) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // Storage write; only accepted writes touch memory.
  always_ff @(posedge Clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= Data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word shown directly from storage; meaningful while not empty.
  assign Data_out = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  // Registered read data: load head on accepted read, hold otherwise.
  always_comb begin
    data_out_d = data_out_q;
    if (Clear_in)       data_out_d = '0;
    else if (rd_accept) data_out_d = mem_q[rd_ptr_q];
  end

  // Read data register.
  always_ff @(posedge Clk) begin
    data_out_q <= data_out_d;
  end

  assign Data_out = data_out_q;
`endif

  // Status outputs decoded from registered state only.
  assign Full_out        = full;
  assign Empty_out       = empty;
  assign Count_out       = count_q;
  assign AlmostFull_out  = (count_q >= AF_LEVEL_C);
  assign AlmostEmpty_out = (count_q <= AE_LEVEL_C);
  assign Overflow_out    = overflow_q;
  assign Underflow_out   = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo -- self-checking bench for sync_fifo (DATA_WIDTH 8,
// ADDRESS_WIDTH 4, default thresholds). A queue-based reference model tracks
// the stored words; a vector table, directed corner sequences and a random
// phase are all compared against it and against hand-derived constants.

module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // Clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b1;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [DW-1:0] din   = '0;

  logic          full_o, empty_o, af_o, ae_o, ovf_o, unf_o;
  logic [DW-1:0] dout_o;
  logic [AW:0]   count_o;

  sync_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .Clk            (clk),
    .Clear_in       (clear),
    .Data_in        (din),
    .WriteEn_in     (we),
    .Full_out       (full_o),
    .Data_out       (dout_o),
    .ReadEn_in      (re),
    .Empty_out      (empty_o),
    .AlmostFull_out (af_o),
    .AlmostEmpty_out(ae_o),
    .Count_out      (count_o),
    .Overflow_out   (ovf_o),
    .Underflow_out  (unf_o)
  );

  // Scoreboard / reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic          clr;
    logic          wr;
    logic          rd;
    logic [DW-1:0] data;
    int            exp_count;
    logic          exp_empty;
    logic          exp_unf;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model of one clock edge, computed from the FIFO rules on the queue.
  task automatic model_edge(input logic c, input logic w, input logic r,
                            input logic [DW-1:0] d);
    int sz;
    sz = exp_q.size();
    if (c) begin
      exp_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_unf = 1'b1;
      if (r && sz > 0)      m_dout = exp_q.pop_front();
      if (w && sz < DEPTH)  exp_q.push_back(d);
    end
  endtask

  // Driver: apply inputs, advance one edge, sample 1 time unit later.
  task automatic cycle(input logic c, input logic w, input logic r,
                       input logic [DW-1:0] d);
    clear = c; we = w; re = r; din = d;
    model_edge(c, w, r, d);
    @(posedge clk);
    #1;
    clear = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, ".count"}, int'(count_o), sz);
    chk({tag, ".empty"}, int'(empty_o), int'(sz == 0));
    chk({tag, ".full"},  int'(full_o),  int'(sz == DEPTH));
    chk({tag, ".af"},    int'(af_o),    int'(sz >= DEPTH - 2));
    chk({tag, ".ae"},    int'(ae_o),    int'(sz <= 2));
    chk({tag, ".ovf"},   int'(ovf_o),   int'(m_ovf));
    chk({tag, ".unf"},   int'(unf_o),   int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    if (sz > 0) chk({tag, ".dout"}, int'(dout_o), int'(exp_q[0]));
`else
    chk({tag, ".dout"}, int'(dout_o), int'(m_dout));
`endif
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, 1'b0, DW'(base + i));
      check_model("fill");
    end
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("rst.count", int'(count_o), 0);
    chk("rst.empty", int'(empty_o), 1);
    chk("rst.full",  int'(full_o),  0);
    chk("rst.ae",    int'(ae_o),    1);
    chk("rst.af",    int'(af_o),    0);
    chk("rst.ovf",   int'(ovf_o),   0);
    chk("rst.unf",   int'(unf_o),   0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst.dout",  int'(dout_o),  0);
`endif

    // Vector table: {clr, wr, rd, data, count, empty, unf, dout}
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h11};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0, 8'h22};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h33};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h33};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b1, 8'h33};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h55, 0, 1'b1, 1'b0, 8'h00};
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].data);
      chk($sformatf("vec%0d.count", i), int'(count_o), vecs[i].exp_count);
      chk($sformatf("vec%0d.empty", i), int'(empty_o), int'(vecs[i].exp_empty));
      chk($sformatf("vec%0d.unf", i),   int'(unf_o),   int'(vecs[i].exp_unf));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("vec%0d.dout", i),  int'(dout_o),  int'(vecs[i].exp_dout));
`endif
      check_model($sformatf("vec%0d", i));
    end

    // Fill 0x01..0x10: almost-full from 14, full at 16, overflow on 17th
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, DW'(i));
      chk($sformatf("fill%0d.af", i), int'(af_o), int'(i >= 14));
      check_model("fill16");
    end
    chk("full.full",  int'(full_o),  1);
    chk("full.count", int'(count_o), 16);
    cycle(1'b0, 1'b1, 1'b0, 8'hAA);
    chk("ovf.flag",  int'(ovf_o),   1);
    chk("ovf.count", int'(count_o), 16);
    check_model("ovf");

    // Drain: data 0x01..0x10 in order, then underflow with held data
    for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("drain%0d.head", i), int'(dout_o), i);
`endif
      cycle(1'b0, 1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("drain%0d.dout", i), int'(dout_o), i);
`endif
      check_model("drain");
    end
    chk("drain.empty", int'(empty_o), 1);
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("unf.flag", int'(unf_o), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("unf.dout_hold", int'(dout_o), 16);
`endif
    check_model("unf");

    // Steady read+write at count 5 for 40 cycles (pointers wrap)
    cycle(1'b1, 1'b0, 1'b0, '0);
    fill(5, 8'h80);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b1, DW'(8'hC0 + i));
      chk("steady.count", int'(count_o), 5);
      check_model("steady");
    end

    // Full plus read+write: write dropped, count 15
    cycle(1'b1, 1'b0, 1'b0, '0);
    fill(DEPTH, 8'h20);
    cycle(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("fullrw.count", int'(count_o), 15);
    chk("fullrw.full",  int'(full_o),  0);
    check_model("fullrw");
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0, 1'b1, '0);
      check_model("fullrw_drain");
    end

    // Empty plus read+write: write taken, count 1
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    chk("emptyrw.count", int'(count_o), 1);
    chk("emptyrw.empty", int'(empty_o), 0);
    check_model("emptyrw");

    // Clear with count 9, flags set and a concurrent write
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    fill(DEPTH, 8'h40);
    cycle(1'b0, 1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    chk("preclr.count", int'(count_o), 9);
    chk("preclr.flags", int'({ovf_o, unf_o}), 3);
    cycle(1'b1, 1'b1, 1'b0, 8'h55);
    chk("clr.count", int'(count_o), 0);
    chk("clr.empty", int'(empty_o), 1);
    chk("clr.ovf",   int'(ovf_o),   0);
    chk("clr.unf",   int'(unf_o),   0);
    check_model("clr");
    cycle(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("postclr.empty", int'(empty_o), 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft.dout", int'(dout_o), 8'h5A);
`endif
    cycle(1'b0, 1'b0, 1'b1, '0);
    check_model("postclr");

    // Random phase against the model
    for (int i = 0; i < 400; i++) begin
      logic c, w, r;
      c = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      cycle(c, w, r, DW'($urandom_range(0, 255)));
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
